prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001: Parameter ADDR_W, default 4, program-RAM address width; maximum program length is 2^ADDR_W bytes.
REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: load_mode  input  1  level; 1 requests programming, 0 requests run/abort.
REQ-005: in_valid  input  1  source has a byte on in_data.
REQ-006: in_data  input  8  program stream byte.
REQ-007: in_ready  output  1  loader accepts a byte this cycle.
REQ-008: mem_we  output  1  one-cycle write strobe to CPU program RAM.
REQ-009: mem_addr  output  ADDR_W  RAM write address.
REQ-010: mem_wdata  output  8  RAM write data.
REQ-011: cpu_run  output  1  releases the CPU core from hold; 1 only after a verified load.
REQ-012: load_err  output  1  sticky error flag for the current load attempt.
REQ-013: busy  output  1  high in HEADER, DATA and CHECK.

Function
REQ-014: A byte transfers only on a rising edge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-015: States: IDLE, HEADER, DATA, CHECK, DONE, ERROR; in_ready is 1 only in HEADER, DATA and CHECK.
REQ-016: IDLE -> HEADER when load_mode=1; on entering HEADER, cpu_run, load_err, write pointer and checksum accumulator clear to 0.
REQ-017: In HEADER, a transferred byte L is the program length; 1 <= L <= 2^ADDR_W goes to DATA, otherwise ERROR.
REQ-018: In DATA, each transferred byte is written to address ptr (starting at 0); ptr increments; the accumulator adds the byte modulo 256.
REQ-019: Write latency is one cycle: mem_we=1 the cycle after the transfer, with mem_addr/mem_wdata equal to that byte's address and value; mem_we=0 in all other cycles.
REQ-020: Back-to-back transfers produce back-to-back mem_we pulses with no lost bytes.
REQ-021: DATA -> CHECK on the transfer of the L-th byte; ptr does not wrap, and L=2^ADDR_W writes the last address (all ones) exactly once.
REQ-022: In CHECK, a transferred byte equal to the accumulator goes to DONE and sets cpu_run=1 on the same edge; a mismatch goes to ERROR and sets load_err=1.
REQ-023: Entering ERROR for any reason sets load_err=1; cpu_run stays 0.
REQ-024: DONE and ERROR exit to IDLE when load_mode=0; cpu_run and load_err hold their values in IDLE.
REQ-025: load_mode=0 during HEADER, DATA or CHECK aborts to IDLE on the next edge, with no further mem_we beyond a pending one-cycle strobe; cpu_run stays 0 and load_err stays 0.
REQ-026: If a transfer and load_mode=0 occur on the same edge, the abort wins and the byte is discarded (no write, no accumulate).
REQ-027: A new load after DONE needs load_mode to fall to 0 (IDLE) and rise again; it clears cpu_run on entering HEADER.

Reset
REQ-028: Synchronous rst=1 forces IDLE; in_ready, mem_we, cpu_run, load_err and busy are 0, and mem_addr, mem_wdata, ptr and accumulator are 0, all on the next edge.
REQ-029: rst asserted mid-load discards the pending write strobe; rst has priority over every transition.

Verification
REQ-030: load_mode=1, stream 03,11,22,33,66 -> writes 0:11, 1:22, 2:33; cpu_run=1 after the checksum edge; load_err=0.
REQ-031: Stream 02,10,20,31 (bad checksum) -> two writes, load_err=1, cpu_run=0.
REQ-032: Header 00, then header 11 (hex, ADDR_W=4) -> ERROR immediately, no mem_we, in_ready=0.
REQ-033: Header 10 (hex) with 16 bytes 00..0F and checksum 78 -> addresses 0..F written once each, cpu_run=1.
REQ-034: load_mode dropped after two of four data bytes -> IDLE, exactly two writes, cpu_run=0, load_err=0; a following full load succeeds.
REQ-035: in_valid toggling every other cycle, and rst pulsed mid-DATA -> no duplicate writes; after rst all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed program byte stream,
// writes it into CPU program RAM and releases the CPU only after a verified load.
module prog_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  // Length register is one bit wider so a full 2^ADDR_W program fits.
  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam int unsigned MAX_LEN = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  len;
  logic [7:0]        acc;

  logic xfer;
  logic len_ok;
  logic last_byte;

  // Handshake, header range check and end-of-data detection.
  assign xfer      = in_valid & in_ready;
  assign len_ok    = (in_data != 8'd0) && (32'(in_data) <= MAX_LEN);
  assign last_byte = ({1'b0, ptr} == (len - LEN_W'(1)));

  // Loader FSM; every output is registered and abort/reset beat any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      load_err  <= 1'b0;
      ptr       <= '0;
      len       <= '0;
      acc       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_mode) begin
            state    <= S_HEADER;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
            ptr      <= '0;
            acc      <= '0;
          end
        end
        S_HEADER: begin
          if (!load_mode) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (xfer) begin
            if (len_ok) begin
              len   <= LEN_W'(in_data);
              state <= S_DATA;
            end else begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              load_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (!load_mode) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            acc       <= acc + in_data;
            // Pointer is held on the last byte so it never wraps.
            if (last_byte) state <= S_CHECK;
            else           ptr   <= ptr + ADDR_W'(1);
          end
        end
        S_CHECK: begin
          if (!load_mode) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == acc) begin
              state   <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              state    <= S_ERROR;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (!load_mode) state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
